// File: rtl/div_seq_ctrl_pkg.sv
// Shared constants for the EX-stage iterative divider sequencer.
//   DIV_DATA_W / DIV_CNT_W : default operand and iteration-counter widths
//   DIV_IDLE..DIV_DONE     : 2-bit sequencer state encodings
//   DIV_RESULT_*           : hi/lo write strobe values
//   STOP / NO_STOP         : stall request values shared with the stall controller
package div_seq_ctrl_pkg;

  localparam int unsigned DIV_DATA_W = 32;
  localparam int unsigned DIV_CNT_W  = 6;

  localparam logic [1:0] DIV_IDLE = 2'd0;
  localparam logic [1:0] DIV_BUSY = 2'd1;
  localparam logic [1:0] DIV_FIX  = 2'd2;
  localparam logic [1:0] DIV_DONE = 2'd3;

  localparam logic DIV_RESULT_READY     = 1'b1;
  localparam logic DIV_RESULT_NOT_READY = 1'b0;

  localparam logic STOP    = 1'b1;
  localparam logic NO_STOP = 1'b0;

endpackage

// File: rtl/div_step.sv
// One combinational restoring shift-subtract step.
//   rem_in  : partial remainder (always < divisor except in the divide-by-zero case)
//   q_in    : shift register holding remaining dividend bits (MSB next) and quotient bits
//   divisor : |b|
//   rem_out : updated partial remainder
//   q_out   : q_in shifted left with the new quotient bit in the LSB
module div_step #(
  parameter int unsigned DATA_W = 32
) (
  input  logic [DATA_W-1:0] rem_in,
  input  logic [DATA_W-1:0] q_in,
  input  logic [DATA_W-1:0] divisor,
  output logic [DATA_W-1:0] rem_out,
  output logic [DATA_W-1:0] q_out
);

  logic [DATA_W:0]   w_shift;
  logic [DATA_W-1:0] w_diff;
  logic              w_ge;

  // Bring the next dividend bit into the remainder; compare at full width.
  assign w_shift = {rem_in, q_in[DATA_W-1]};
  assign w_ge    = (w_shift >= {1'b0, divisor});
  // Low bits of the difference are exact whenever w_ge holds.
  assign w_diff  = w_shift[DATA_W-1:0] - divisor;

  assign rem_out = w_ge ? w_diff : w_shift[DATA_W-1:0];
  assign q_out   = {q_in[DATA_W-2:0], w_ge};

endmodule

// File: rtl/div_seq_ctrl.sv
// Sequencer for the EX-stage iterative divider (div/divu).
// Latches |a|,|b| on start, runs DATA_W restoring steps, sign-corrects, and
// presents remainder on hi_o and quotient on lo_o with a result_valid strobe.
// Ports:
//   clk, rst        : clock; synchronous active-low reset
//   start           : EX holds a div/divu with valid operands
//   signed_div      : 1 = div, 0 = divu (sampled with start)
//   annul           : flush the in-flight op, no result is produced
//   hold            : downstream stall, freezes DONE
//   opdata1/opdata2 : dividend / divisor
//   stallreq        : combinational stall request ((IDLE&start)|BUSY|FIX)
//   busy            : sequencer not idle
//   result_valid    : hi/lo write strobe
//   hi_o / lo_o     : remainder / quotient, held outside DONE
// Build option: define DIV_ZERO_FAST_EN to finish a zero-divisor op in one cycle.
module div_seq_ctrl
  import div_seq_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W = DIV_DATA_W,
  parameter int unsigned CNT_W  = DIV_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              signed_div,
  input  logic              annul,
  input  logic              hold,
  input  logic [DATA_W-1:0] opdata1,
  input  logic [DATA_W-1:0] opdata2,
  output logic              stallreq,
  output logic              busy,
  output logic              result_valid,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o
);

  logic [1:0]        r_state;
  logic [1:0]        w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_rem;
  logic [DATA_W-1:0] r_quo;
  logic [DATA_W-1:0] r_div;
  logic              r_neg_q;
  logic              r_neg_r;
  logic              r_busy;
  logic              r_result_valid;

  logic [DATA_W-1:0] w_abs_a;
  logic [DATA_W-1:0] w_abs_b;
  logic [DATA_W-1:0] w_rem_step;
  logic [DATA_W-1:0] w_quo_step;
  logic              w_zero_fast;
  logic              w_accept;

`ifdef DIV_ZERO_FAST_EN
  assign w_zero_fast = (opdata2 == '0);
`else
  assign w_zero_fast = 1'b0;
`endif

  // Magnitudes are taken only for signed ops; 0x80000000 maps to itself as unsigned.
  assign w_abs_a  = (signed_div && opdata1[DATA_W-1]) ? (~opdata1 + DATA_W'(1)) : opdata1;
  assign w_abs_b  = (signed_div && opdata2[DATA_W-1]) ? (~opdata2 + DATA_W'(1)) : opdata2;
  // Annul in the same cycle as start cancels the op before anything is latched.
  assign w_accept = start && !annul;

  div_step #(.DATA_W(DATA_W)) u_div_step (
    .rem_in  (r_rem),
    .q_in    (r_quo),
    .divisor (r_div),
    .rem_out (w_rem_step),
    .q_out   (w_quo_step)
  );

  // Next-state and stall request.
  always_comb begin
    w_state_nxt = r_state;
    stallreq    = NO_STOP;
    case (r_state)
      DIV_IDLE: begin
        if (start) stallreq = STOP;
        if (w_accept) w_state_nxt = w_zero_fast ? DIV_DONE : DIV_BUSY;
      end
      DIV_BUSY: begin
        stallreq = STOP;
        if (annul) w_state_nxt = DIV_IDLE;
        else if (r_cnt == CNT_W'(DATA_W - 1)) w_state_nxt = DIV_FIX;
      end
      DIV_FIX: begin
        stallreq    = STOP;
        w_state_nxt = annul ? DIV_IDLE : DIV_DONE;
      end
      DIV_DONE: begin
        if (annul || !hold) w_state_nxt = DIV_IDLE;
      end
      default: w_state_nxt = DIV_IDLE;
    endcase
  end

  // State register, datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state        <= DIV_IDLE;
      r_cnt          <= '0;
      r_rem          <= '0;
      r_quo          <= '0;
      r_div          <= '0;
      r_neg_q        <= 1'b0;
      r_neg_r        <= 1'b0;
      r_busy         <= 1'b0;
      r_result_valid <= DIV_RESULT_NOT_READY;
      hi_o           <= '0;
      lo_o           <= '0;
    end else begin
      r_state        <= w_state_nxt;
      r_busy         <= (w_state_nxt != DIV_IDLE);
      r_result_valid <= (w_state_nxt == DIV_DONE) ? DIV_RESULT_READY : DIV_RESULT_NOT_READY;
      case (r_state)
        DIV_IDLE: begin
          if (w_accept) begin
            r_quo   <= w_abs_a;
            r_div   <= w_abs_b;
            r_rem   <= '0;
            r_cnt   <= '0;
            r_neg_q <= signed_div && (opdata1[DATA_W-1] != opdata2[DATA_W-1]);
            r_neg_r <= signed_div && opdata1[DATA_W-1];
            // Zero divisor shortcut: same bits the full run would produce.
            if (w_zero_fast) begin
              hi_o <= opdata1;
              lo_o <= (signed_div && opdata1[DATA_W-1]) ? DATA_W'(1) : '1;
            end
          end
        end
        DIV_BUSY: begin
          r_rem <= w_rem_step;
          r_quo <= w_quo_step;
          r_cnt <= r_cnt + CNT_W'(1);
        end
        DIV_FIX: begin
          if (!annul) begin
            hi_o <= r_neg_r ? (~r_rem + DATA_W'(1)) : r_rem;
            lo_o <= r_neg_q ? (~r_quo + DATA_W'(1)) : r_quo;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy         = r_busy;
  assign result_valid = r_result_valid;

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Scoreboard bench for div_seq_ctrl: stimulus pushes expected hi/lo/latency,
// a negedge monitor pops and compares on each new result_valid.
module tb_div_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        signed_div = 1'b0;
  logic        annul = 1'b0;
  logic        hold = 1'b0;
  logic [31:0] opdata1 = '0;
  logic [31:0] opdata2 = '0;
  logic        stallreq;
  logic        busy;
  logic        result_valid;
  logic [31:0] hi_o;
  logic [31:0] lo_o;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
    int          start_cyc;
    int          id;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   op_id = 0;
  logic prev_valid = 1'b0;

`ifdef DIV_ZERO_FAST_EN
  localparam int ZERO_LAT = 1;
`else
  localparam int ZERO_LAT = 34;
`endif

  div_seq_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .signed_div   (signed_div),
    .annul        (annul),
    .hold         (hold),
    .opdata1      (opdata1),
    .opdata2      (opdata2),
    .stallreq     (stallreq),
    .busy         (busy),
    .result_valid (result_valid),
    .hi_o         (hi_o),
    .lo_o         (lo_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compare on the first cycle of each result_valid assertion.
  always @(negedge clk) begin
    if (rst && result_valid && !prev_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got hi=0x%08h lo=0x%08h, expected no result", hi_o, lo_o);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk($sformatf("op%0d_hi", e.id), hi_o, e.hi);
        chk($sformatf("op%0d_lo", e.id), lo_o, e.lo);
        chk($sformatf("op%0d_latency", e.id), 32'(cyc - e.start_cyc), 32'(e.lat));
      end
    end
    prev_valid = result_valid;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called just after a posedge: drive start for one cycle and record the expectation.
  task automatic issue(input logic s, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] ehi, input logic [31:0] elo, input int lat);
    exp_t e;
    op_id++;
    e.hi = ehi; e.lo = elo; e.lat = lat; e.start_cyc = cyc; e.id = op_id;
    exp_q.push_back(e);
    signed_div = s; opdata1 = a; opdata2 = b; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Wait (bounded) until the monitor has consumed every expectation.
  task automatic drain();
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: got %0d pending results, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic run_op(input logic s, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] ehi, input logic [31:0] elo, input int lat);
    issue(s, a, b, ehi, elo, lat);
    drain();
  endtask

  initial begin
    logic [31:0] sv_hi, sv_lo;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_valid", 32'(result_valid), 32'd0);
    chk("reset_stallreq", 32'(stallreq), 32'd0);
    chk("reset_hi", hi_o, 32'd0);
    chk("reset_lo", lo_o, 32'd0);
    tick();

    // divu 100/7 with per-cycle stall request profile.
    op_id++;
    exp_q.push_back('{hi: 32'd2, lo: 32'd14, lat: 34, start_cyc: cyc, id: op_id});
    signed_div = 1'b0; opdata1 = 32'd100; opdata2 = 32'd7; start = 1'b1;
    for (int c = 0; c <= 34; c++) begin
      @(negedge clk);
      chk($sformatf("stallreq_c%0d", c), 32'(stallreq), (c <= 33) ? 32'd1 : 32'd0);
      tick();
      if (c == 0) start = 1'b0;
    end
    drain();

    run_op(1'b1, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFF, 32'hFFFF_FFFD, 34);
    run_op(1'b1, 32'd7,         32'hFFFF_FFFE,  32'd1,         32'hFFFF_FFFD, 34);
    run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF,  32'd0,         32'h8000_0000, 34);
    run_op(1'b0, 32'hFFFF_FFFF, 32'd16,         32'd15,        32'h0FFF_FFFF, 34);

    // Annul during the 10th BUSY cycle: no result for this op.
    signed_div = 1'b0; opdata1 = 32'd999; opdata2 = 32'd3; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (9) tick();
    annul = 1'b1;
    tick();
    annul = 1'b0;
    @(negedge clk);
    chk("annul_busy", 32'(busy), 32'd0);
    chk("annul_stallreq", 32'(stallreq), 32'd0);
    chk("annul_valid", 32'(result_valid), 32'd0);
    repeat (40) tick();
    run_op(1'b0, 32'd1000, 32'd33, 32'd10, 32'd30, 34);

    // Hold in DONE for 3 cycles with start asserted: 4 stable valid cycles.
    issue(1'b0, 32'd50, 32'd6, 32'd2, 32'd8, 34);
    hold = 1'b1;
    for (int i = 0; i < 60 && !result_valid; i++) @(negedge clk);
    chk("hold_reach_done", 32'(result_valid), 32'd1);
    sv_hi = hi_o; sv_lo = lo_o;
    start = 1'b1; opdata1 = 32'd77; opdata2 = 32'd5;
    for (int j = 1; j <= 3; j++) begin
      @(negedge clk);
      chk($sformatf("hold_valid_%0d", j), 32'(result_valid), 32'd1);
      chk($sformatf("hold_hi_%0d", j), hi_o, sv_hi);
      chk($sformatf("hold_lo_%0d", j), lo_o, sv_lo);
      if (j == 3) begin
        hold = 1'b0;
        start = 1'b0;
      end
    end
    @(negedge clk);
    chk("hold_exit_valid", 32'(result_valid), 32'd0);
    chk("hold_exit_busy", 32'(busy), 32'd0);
    tick();
    drain();

    // Zero divisor, unsigned and signed.
    run_op(1'b0, 32'd5,         32'd0, 32'd5,         32'hFFFF_FFFF, ZERO_LAT);
    run_op(1'b1, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'd1,         ZERO_LAT);
    run_op(1'b1, 32'd9,         32'd0, 32'd9,         32'hFFFF_FFFF, ZERO_LAT);

    // Reset mid-BUSY: everything clears, no result.
    signed_div = 1'b0; opdata1 = 32'd123; opdata2 = 32'd4; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    @(negedge clk);
    chk("rstmid_busy", 32'(busy), 32'd0);
    chk("rstmid_valid", 32'(result_valid), 32'd0);
    chk("rstmid_stallreq", 32'(stallreq), 32'd0);
    chk("rstmid_hi", hi_o, 32'd0);
    chk("rstmid_lo", lo_o, 32'd0);
    repeat (40) tick();

    run_op(1'b0, 32'd123, 32'd4, 32'd3, 32'd30, 34);
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout at cycle %0d, expected completion", cyc);
    $fatal(1, "watchdog");
  end

endmodule
